robertson_mult_seq: RTL and testbench

Parametrised sequential shift-add multiplier implementing Robertson's algorithm for N-bit operands. It produces a 2N-bit product, selectable per operation as signed (two's complement) or unsigned. It folds the existing discrete parts (registers, add/sub, down-counter, micro-sequencer) into one self-timed block with a start/busy/done handshake. It sits between the operand registers and the result bus of the multiplier datapath.

---
 rtl/robs_pkg.sv | 18 +
 rtl/robs_step.sv | 29 ++
 rtl/robertson_mult_seq.sv | 98 +++++++++
 tb/tb_robertson_mult_seq.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/robs_pkg.sv
// Shared definitions for the Robertson sequential multiplier: state codes,
// counter sizing and the operand extension bit.
package robs_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  function automatic int robs_cw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Bit prepended when widening an N-bit value to N+1 bits.
  function automatic logic robs_ext(input logic msb, input logic mode);
    return mode & msb;
  endfunction

endpackage

// File: rtl/robs_step.sv
// One Robertson step: N+1-bit add (or subtract on the final signed step)
// of the extended partial product, returned already shifted right by one.
module robs_step
  import robs_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] m_i,
  input  logic         q0_i,
  input  logic         mode_i,
  input  logic         last_i,
  output logic [N-1:0] a_o,
  output logic         sbit_o
);

  logic [N:0] ext_a, p, s;

  always_comb begin
    ext_a = {robs_ext(a_i[N-1], mode_i), a_i};
    p     = q0_i ? {robs_ext(m_i[N-1], mode_i), m_i} : '0;
    // The multiplier sign bit carries weight -2^(N-1) in signed mode.
    s     = (mode_i && last_i) ? (ext_a - p) : (ext_a + p);
  end

  assign a_o    = s[N:1];
  assign sbit_o = s[0];

endmodule

// File: rtl/robertson_mult_seq.sv
// Sequential N x N -> 2N multiplier (signed or unsigned per operation),
// one add/shift step per clock with a start/busy/done handshake.
module robertson_mult_seq
  import robs_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           is_signed,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic [2*N-1:0] product,
  output logic           busy,
  output logic           done
);

  localparam int CW = robs_cw(N);

  logic [1:0]     state_q, state_d;
  logic [N-1:0]   a_q, a_d, q_q, q_d, m_q, m_d;
  logic           mode_q, mode_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] prod_q, prod_d;
  logic [N-1:0]   a_step;
  logic           s0;

  robs_step #(.N(N)) u_step (
    .a_i   (a_q),
    .m_i   (m_q),
    .q0_i  (q_q[0]),
    .mode_i(mode_q),
    .last_i(cnt_q == '0),
    .a_o   (a_step),
    .sbit_o(s0)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          a_d     = '0;
          q_d     = multiplier;
          m_d     = multiplicand;
          mode_d  = is_signed;
          cnt_d   = CW'(N - 1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_d = a_step;
        q_d = {s0, q_q[N-1:1]};
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          prod_d  = {a_step, s0, q_q[N-1:1]};
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  assign product = prod_q;
  assign busy    = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_robertson_mult_seq.sv
// Directed bench for robertson_mult_seq at N=8 and N=4; a negedge monitor
// compares every done pulse against a queue of hand-computed products.
module tb_robertson_mult_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start8, sgn8, busy8, done8;
  logic [7:0]  mc8, mq8;
  logic [15:0] prod8;
  logic        start4, sgn4, busy4, done4;
  logic [3:0]  mc4, mq4;
  logic [7:0]  prod4;

  robertson_mult_seq #(.N(8)) u8 (
    .clk(clk), .reset(reset), .start(start8), .is_signed(sgn8),
    .multiplicand(mc8), .multiplier(mq8),
    .product(prod8), .busy(busy8), .done(done8)
  );

  robertson_mult_seq #(.N(4)) u4 (
    .clk(clk), .reset(reset), .start(start4), .is_signed(sgn4),
    .multiplicand(mc4), .multiplier(mq4),
    .product(prod4), .busy(busy4), .done(done4)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] sb8[$];
  logic [7:0]  sb4[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done8) begin
      if (sb8.size() == 0) chk("done8_unexpected", 32'd1, 32'd0);
      else chk("prod8", 32'(prod8), 32'(sb8.pop_front()));
    end
    if (done8 && busy8) chk("done8_and_busy8", 32'd1, 32'd0);
    if (done4) begin
      if (sb4.size() == 0) chk("done4_unexpected", 32'd1, 32'd0);
      else chk("prod4", 32'(prod4), 32'(sb4.pop_front()));
    end
    if (done4 && busy4) chk("done4_and_busy4", 32'd1, 32'd0);
  end

  // Called at #1 after an edge; returns at #1 after the start-sampling edge.
  task automatic issue8(input logic s, input logic [7:0] m, input logic [7:0] q,
                        input logic [15:0] exp);
    start8 = 1'b1; sgn8 = s; mc8 = m; mq8 = q;
    sb8.push_back(exp);
    @(posedge clk); #1;
    start8 = 1'b0;
    chk("busy8_after_start", 32'(busy8), 32'd1);
  endtask

  task automatic issue4(input logic s, input logic [3:0] m, input logic [3:0] q,
                        input logic [7:0] exp);
    start4 = 1'b1; sgn4 = s; mc4 = m; mq4 = q;
    sb4.push_back(exp);
    @(posedge clk); #1;
    start4 = 1'b0;
    chk("busy4_after_start", 32'(busy4), 32'd1);
  endtask

  // Edges until done, counted after the start-sampling edge; bounded.
  task automatic wait8(input int exp_edges, input string nm);
    int e = 0;
    do begin @(posedge clk); #1; e++; end while (!done8 && e < 40);
    chk(nm, 32'(e), 32'(exp_edges));
  endtask

  task automatic wait4(input int exp_edges, input string nm);
    int e = 0;
    do begin @(posedge clk); #1; e++; end while (!done4 && e < 40);
    chk(nm, 32'(e), 32'(exp_edges));
  endtask

  initial begin
    int busy_cnt, dn;
    reset = 1'b1;
    start8 = 0; sgn8 = 0; mc8 = 0; mq8 = 0;
    start4 = 0; sgn4 = 0; mc4 = 0; mq4 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy8", 32'(busy8), 0);
    chk("rst_done8", 32'(done8), 0);
    chk("rst_prod8", 32'(prod8), 0);
    chk("rst_prod4", 32'(prod4), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 3 x 5 signed: busy for 8 cycles, done on the 9th edge counting start
    issue8(1'b1, 8'h03, 8'h05, 16'h000F);
    busy_cnt = 1;
    dn = 0;
    do begin
      @(posedge clk); #1; dn++;
      if (busy8) busy_cnt++;
    end while (!done8 && dn < 40);
    chk("lat8_edges_incl_start", 32'(dn + 1), 32'd9);
    chk("busy8_cycles", 32'(busy_cnt), 32'd8);

    issue8(1'b1, 8'hFD, 8'h05, 16'hFFF1); wait8(8, "lat8_neg");
    issue8(1'b1, 8'h80, 8'h80, 16'h4000); wait8(8, "lat8_minmin");
    issue8(1'b0, 8'hFF, 8'hFF, 16'hFE01); wait8(8, "lat8_uff");
    issue8(1'b1, 8'hFF, 8'hFF, 16'h0001); wait8(8, "lat8_sff");
    issue8(1'b1, 8'h00, 8'hFF, 16'h0000); wait8(8, "lat8_zero");
    @(posedge clk); @(posedge clk); #1;
    chk("prod8_hold_idle", 32'(prod8), 32'h0000);

    // start during RUN ignored (12 x -10 = -120)
    issue8(1'b1, 8'h0C, 8'hF6, 16'hFF88);
    repeat (3) @(posedge clk);
    #1;
    start8 = 1'b1; sgn8 = 1'b0; mc8 = 8'h55; mq8 = 8'h33;
    repeat (2) @(posedge clk);
    #1;
    start8 = 1'b0;
    wait8(3, "lat8_run_start_ignored");

    // back-to-back: second start issued in the DONE cycle
    issue8(1'b0, 8'h80, 8'h02, 16'h0100); wait8(8, "lat8_b2b_a");
    issue8(1'b1, 8'h7F, 8'h7F, 16'h3F01); wait8(8, "lat8_b2b_b");
    @(posedge clk); #1;
    chk("prod8_hold_after_done", 32'(prod8), 32'h3F01);

    // reset at RUN step 4 aborts with no done pulse
    issue8(1'b1, 8'h11, 8'h22, 16'h0242);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy8", 32'(busy8), 0);
    chk("abort_done8", 32'(done8), 0);
    chk("abort_prod8", 32'(prod8), 0);
    sb8.delete();
    dn = 0;
    repeat (12) begin @(posedge clk); #1; if (done8) dn++; end
    chk("abort_no_done", 32'(dn), 0);
    issue8(1'b1, 8'h07, 8'h07, 16'h0031); wait8(8, "lat8_after_abort");

    // N=4: done 5 edges counting the start edge
    issue4(1'b1, 4'h8, 4'h7, 8'hC8); wait4(4, "lat4_signed");
    issue4(1'b0, 4'hF, 4'hF, 8'hE1); wait4(4, "lat4_unsigned");

    repeat (3) @(posedge clk);
    #1;
    chk("sb8_drained", 32'(sb8.size()), 0);
    chk("sb4_drained", 32'(sb4.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
